// File: rtl/serial_adder_n_if.sv
// serial_adder_n_if: operand/result bundle for the bit-serial adder.
//
// Handshake: the master raises start_i together with sub_i/a_i/b_i/ci_i.
// The slave takes the request at a rising clock edge only while ready_o=1,
// so a request is accepted on an edge where start_i && ready_o. From that
// edge on, the operand lines are don't-care. done_o is a one-cycle pulse in
// the cycle that follows the update of sum_o/co_o (and ov_o). The request
// side needs no backpressure because done_o cannot be stalled.
//
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN adds the ov_o line.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ci_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             co_o;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ov_o;
`endif

  modport master (
    output start_i, sub_i, a_i, b_i, ci_i,
    input  ready_o, done_o, sum_o, co_o
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , ov_o
`endif
  );

  modport slave (
    input  start_i, sub_i, a_i, b_i, ci_i,
    output ready_o, done_o, sum_o, co_o
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , ov_o
`endif
  );
endinterface

// File: rtl/serial_adder_n.sv
// serial_adder_n: bit-serial N-bit adder/subtractor built around one
// full-adder cell. One operand bit pair is consumed per clock, LSB first.
// Subtraction is A + ~B + 1, so co_o=1 means "no borrow".
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN (signed overflow flag ov_o).
// dbg_state_o exposes the FSM state (0=IDLE, 1=RUN, 2=DONE).
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  serial_adder_n_if.slave       bus,
  output logic [1:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               co_q, co_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic               ov_q, ov_d;
`endif

  // The single full-adder cell, fed by the bit selected by the counter.
  logic a_bit, b_bit, fa_sum, fa_carry;
  assign a_bit    = a_q[cnt_q];
  assign b_bit    = b_q[cnt_q];
  assign fa_sum   = a_bit ^ b_bit ^ carry_q;
  assign fa_carry = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

  // State and datapath registers; reset clears everything and aborts any op.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ov_q    <= ov_d;
`endif
    end
  end

  // Next-state and datapath update: capture in IDLE, one bit per RUN edge,
  // publish the result on the last RUN edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ov_d    = ov_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          b_d     = bus.sub_i ? ~bus.b_i : bus.b_i;
          carry_d = bus.sub_i ? 1'b1 : bus.ci_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[cnt_q] = fa_sum;
        carry_d      = fa_carry;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB, fa_carry the carry out of it.
          sum_d   = res_d;
          co_d    = fa_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ov_d    = carry_q ^ fa_carry;
`endif
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.done_o  = (state_q == DONE);
  assign bus.sum_o   = sum_q;
  assign bus.co_o    = co_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign bus.ov_o    = ov_q;
`endif
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: directed bench for serial_adder_n (WIDTH=8), plus a
// WIDTH=3 exhaustive sweep when SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_serial_adder_n;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_n_if #(.WIDTH(W)) bus ();
  logic [1:0] dbg_state;

  serial_adder_n #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

`ifdef SERIAL_ADDER_OVERFLOW_EN
  serial_adder_n_if #(.WIDTH(3)) bus3 ();
  logic [1:0] dbg_state3;

  serial_adder_n #(.WIDTH(3)) dut3 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (bus3),
    .dbg_state_o (dbg_state3)
  );
`endif

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One full operation on the WIDTH=8 unit with hand-computed expectations.
  task automatic run_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] es, input logic eco,
                        input logic eov, input string tag);
    int lat;
    logic [W:0] exp_v;
    exp_q.push_back({eco, es});
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.sub_i   = sub;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.ci_i    = ci;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.a_i     = 8'(~a);
    bus.b_i     = 8'(~b);
    check({tag, " ready_low"}, 32'(bus.ready_o), 32'd0);
    lat = 1;
    while (!bus.done_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    // negedge count since the start edge: done follows edge E0+W
    check({tag, " latency"}, 32'(lat), 32'(W + 1));
    exp_v = exp_q.pop_front();
    check({tag, " sum"}, 32'(bus.sum_o), 32'(exp_v[W-1:0]));
    check({tag, " co"}, 32'(bus.co_o), 32'(exp_v[W]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check({tag, " ov"}, 32'(bus.ov_o), 32'(eov));
`else
    if (eov === 1'bx) check({tag, " ov_arg"}, 32'(eov), 32'd0);
`endif
    @(negedge clk);
    check({tag, " done_pulse_end"}, 32'(bus.done_o), 32'd0);
    check({tag, " ready_back"}, 32'(bus.ready_o), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pulses;
    int quiet_done;
    bus.start_i = 1'b0;
    bus.sub_i   = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.ci_i    = 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    bus3.start_i = 1'b0;
    bus3.sub_i   = 1'b0;
    bus3.a_i     = '0;
    bus3.b_i     = '0;
    bus3.ci_i    = 1'b0;
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst ready", 32'(bus.ready_o), 32'd1);
    check("rst done", 32'(bus.done_o), 32'd0);
    check("rst sum", 32'(bus.sum_o), 32'd0);
    check("rst co", 32'(bus.co_o), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("rst ov", 32'(bus.ov_o), 32'd0);
`endif
    rst_n = 1'b1;

    // main function
    run_op(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "add_zero");
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap");
    run_op(1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, "add_ci");
    run_op(1'b1, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, "sub_pos");
    run_op(1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, "sub_neg");

    // start held high and operands toggled during RUN
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.sub_i   = 1'b0;
    bus.a_i     = 8'h10;
    bus.b_i     = 8'h20;
    bus.ci_i    = 1'b0;
    @(negedge clk);
    bus.a_i = 8'hFF;
    bus.b_i = 8'hFF;
    bus.ci_i = 1'b1;
    check("hold prior_sum", 32'(bus.sum_o), 32'h0FE);
    check("hold prior_co", 32'(bus.co_o), 32'd0);
    pulses = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        pulses++;
        if (pulses == 1) begin
          check("hold sum", 32'(bus.sum_o), 32'h030);
          check("hold co", 32'(bus.co_o), 32'd0);
        end
        bus.start_i = 1'b0;
      end else if (bus.start_i) begin
        bus.a_i = 8'($urandom_range(0, 255));
        bus.b_i = 8'($urandom_range(0, 255));
        if (pulses == 0) check("hold sum_stable", 32'(bus.sum_o), 32'h0FE);
      end
    end
    check("hold pulses", 32'(pulses), 32'd1);
    check("hold ready", 32'(bus.ready_o), 32'd1);

    // reset at the 3rd RUN edge
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = 8'h33;
    bus.b_i     = 8'h44;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort done", 32'(bus.done_o), 32'd0);
    check("abort sum", 32'(bus.sum_o), 32'd0);
    check("abort co", 32'(bus.co_o), 32'd0);
    rst_n = 1'b1;
    quiet_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done_o) quiet_done++;
    end
    check("abort no_done", 32'(quiet_done), 32'd0);
    check("abort ready", 32'(bus.ready_o), 32'd1);

    run_op(1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_OVERFLOW_EN
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ov_add");
    run_op(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "ov_sub");
    run_op(1'b0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, "ov_none");

    // exhaustive WIDTH=3 sweep against a signed/unsigned reference
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int a = 0; a < 8; a++) begin
          for (int b = 0; b < 8; b++) begin
            logic [2:0] av, bv, bb;
            logic       cin;
            logic [3:0] ref_v;
            logic       ref_ov;
            int         wt;
            av     = 3'(a);
            bv     = 3'(b);
            bb     = (s != 0) ? ~bv : bv;
            cin    = (s != 0) ? 1'b1 : 1'(c);
            ref_v  = {1'b0, av} + {1'b0, bb} + {3'b000, cin};
            ref_ov = (av[2] == bb[2]) && (ref_v[2] != av[2]);
            @(negedge clk);
            bus3.start_i = 1'b1;
            bus3.sub_i   = 1'(s);
            bus3.a_i     = av;
            bus3.b_i     = bv;
            bus3.ci_i    = 1'(c);
            @(negedge clk);
            bus3.start_i = 1'b0;
            wt = 0;
            while (!bus3.done_o && wt < 20) begin
              @(negedge clk);
              wt++;
            end
            check($sformatf("w3 s%0d c%0d a%0d b%0d", s, c, a, b),
                  {27'd0, bus3.ov_o, bus3.co_o, bus3.sum_o},
                  {27'd0, ref_ov, ref_v});
            @(negedge clk);
          end
        end
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised bit-serial adder/subtractor; the multi-bit, sequential successor to the combinational one-bit full adder.
- Reuses one full-adder cell, processing one bit per clock from LSB to MSB.
- Results are delivered through a start/ready/done handshake.
- Sits in the combinational-logic lab area as the area-minimal N-bit arithmetic unit for later datapath exercises.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  reset; synchronous, active-low.
- start_i  input  1  request; sampled only while ready_o=1.
- sub_i  input  1  0 = add, 1 = subtract (a_i - b_i); captured with start.
- a_i  input  WIDTH  operand A; captured with start.
- b_i  input  WIDTH  operand B; captured with start.
- ci_i  input  1  carry-in for add; ignored when sub_i=1.
- ready_o  output  1  high only in IDLE.
- done_o  output  1  one-cycle pulse when sum_o/co_o update.
- sum_o  output  WIDTH  registered result.
- co_o  output  1  registered carry-out; in subtract mode 1 = no borrow (a_i >= b_i unsigned).
- ov_o  output  1  signed overflow; present only with OVERFLOW_EN.

Behaviour:
- Clocking: one clock, clk_i. Reset is synchronous and active-low on rst_n_i.
- Reset (rst_n_i=0 at an edge):
  - state=IDLE, bit counter=0, internal shift/carry regs=0.
  - sum_o=0, co_o=0, done_o=0, ov_o=0.
  - ready_o=1 from the first cycle after that edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - start_i=1 at an edge:
    - Capture A=a_i, B = sub_i ? ~b_i : b_i, carry = sub_i ? 1 : ci_i.
    - Clear counter; go to RUN.
  - start_i=0: stay in IDLE.
- RUN:
  - Each edge computes bit = A[cnt]^B[cnt]^carry and carry = maj(A[cnt],B[cnt],carry).
  - Bit is shifted into the internal result register; cnt increments.
  - At the edge where cnt==WIDTH-1: load sum_o, co_o (and ov_o) from internal regs; go to DONE.
  - start_i is ignored.
- DONE:
  - done_o=1 for exactly this one cycle; ready_o=0; next edge goes to IDLE. start_i is ignored.
- Latency: start accepted at edge E0; done_o high in the cycle following edge E0+WIDTH.
- Throughput: one operation per WIDTH+2 cycles.
- Output hold: sum_o/co_o/ov_o change only on the RUN->DONE edge or reset. They hold through IDLE and the next RUN.
- Width rules:
  - Result is the exact (WIDTH+1)-bit sum {co_o,sum_o} = A + B + carry, where B and carry are the captured (possibly inverted/forced) values.
  - No truncation beyond co_o.
- Wrap-around: all-ones plus one gives sum_o=0, co_o=1.
- Operand changes after capture have no effect.
- Reset mid-RUN or in DONE: operation aborted, no done_o pulse, outputs cleared to 0.
- Simultaneous start_i and reset: reset wins.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN
- Defined:
  - ov_o port exists; ov_o = carry into MSB XOR carry out of MSB.
  - Captured on the RUN->DONE edge; reset 0.
- Undefined:
  - ov_o port and its carry-into-MSB register are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, reset, then start with a=8'h00 b=8'h00 ci=0 sub=0 -> ready_o drops; done_o pulses 8 cycles after the start edge; sum_o=8'h00 co_o=0; ready_o=1 next cycle.
- a=8'hFF b=8'h01 ci=0 -> sum_o=8'h00 co_o=1. Then a=8'hA5 b=8'h5A ci=1 -> sum_o=8'h00 co_o=1.
- sub=1, a=8'h07 b=8'h05 ci=1 -> sum_o=8'h02 co_o=1 (ci ignored). Then sub=1, a=8'h05 b=8'h07 -> sum_o=8'hFE co_o=0.
- Start a=8'h10 b=8'h20. Hold start_i=1 and change a_i/b_i during RUN -> exactly one done_o pulse, sum_o=8'h30. sum_o keeps its prior value until that done.
- Start, then rst_n_i=0 at the 3rd RUN edge -> no done_o, sum_o=0, co_o=0, ready_o=1 after reset is released.
- With SERIAL_ADDER_OVERFLOW_EN:
  - a=8'h7F b=8'h01 add -> sum_o=8'h80 ov_o=1.
  - a=8'h80 b=8'h01 sub -> sum_o=8'h7F ov_o=1.
  - a=8'h05 b=8'h03 add -> ov_o=0.
  - Also run an exhaustive sweep at WIDTH=3 against a reference sum.
